stepper_move_scheduler: RTL and testbench
=========================================

// Module: stepper_move_scheduler
// PURPOSE
//  Sequences absolute-position moves of the single shared stepper axis for multiple parking/charging bay requesters.
//  Round-robin arbitrates target-position requests and tracks the absolute step position from step feedback.
//  Drives coord_enable/coord_run/coord_dir of stepper_motor_controller, with one step counted per motor_step rising edge.
//  After each move it waits a settle period, then reports completion to the granted requester.
// PARAMETERS
//  NUM_REQ        4        number of requesters (>=2)
//  POS_WIDTH      16       width of absolute position / step counters
//  SETTLE_CYCLES  50_000   clk cycles held after run drops before done (1 ms @ 50 MHz); >=1
// PORTS
//  clk           in   1                    system clock, 50 MHz
//  rst_n         in   1                    reset, asynchronous, active-low
//  req           in   NUM_REQ              level request per requester; held until grant
//  req_pos       in   NUM_REQ*POS_WIDTH    target position, requester i at [i*POS_WIDTH +: POS_WIDTH]
//  abort         in   1                    terminate current move (level, sampled each cycle)
//  home_set      in   1                    force cur_pos to 0 (honoured in IDLE only)
//  step_fb       in   1                    motor_step from the controller (same clock domain)
//  grant         out  NUM_REQ              one-hot, 1-cycle pulse when a request is accepted
//  done          out  NUM_REQ              one-hot, 1-cycle pulse to the granted requester at move end
//  aborted       out  1                    valid with done: 1 = move was aborted
//  busy          out  1                    1 in every state except IDLE
//  cur_pos       out  POS_WIDTH            absolute position in steps
//  coord_enable  out  1                    high in RUN and SETTLE (manual control is locked out)
//  coord_run     out  1                    high in RUN only
//  coord_dir     out  1                    0 = forward (position increases), 1 = reverse
// BEHAVIOUR
//  Reset: all outputs 0, cur_pos=0, RR pointer=0, state IDLE, step-edge register 0. Reset mid-move abandons the move silently (no done pulse).
//  Step edge: step_e = step_fb & ~step_fb_q. Every step_e in any state does cur_pos +1 (dir 0) or -1 (dir 1), dir = last latched direction.
//  cur_pos: unsigned, no saturation. A move never crosses 0 or 2^POS_WIDTH-1, since direction comes from comparison.
//  States and transitions:
//   IDLE:   if home_set, cur_pos<=0; home_set takes priority over req in the same cycle.
//           Else if |req: pick first set bit searching from ptr upward, wrapping.
//           Next cycle: grant[id]=1, target<=req_pos[id], ptr<=id+1 mod NUM_REQ; go CALC.
//   CALC:   (1 cycle) dir<=(target<cur_pos); remaining<=|target-cur_pos|.
//           If abort, go DONE (aborted=1). Else if remaining==0, go DONE (aborted=0). Else go RUN.
//   RUN:    coord_enable=1, coord_run=1, coord_dir=dir.
//           On step_e: remaining-1; if remaining was 1, go SETTLE, and coord_run is 0 from the next cycle.
//           If abort: go SETTLE with aborted latched 1; abort wins over a simultaneous final step_e, but that step is still counted.
//   SETTLE: coord_enable=1, coord_run=0. Count SETTLE_CYCLES cycles, then go DONE. Late step edges still update cur_pos.
//   DONE:   done[id]=1 and aborted valid for exactly 1 cycle; go IDLE.
//  A req deasserted before grant is dropped. req/req_pos changes after grant are ignored.
//  abort in IDLE/SETTLE/DONE is ignored (apart from the flag already latched).
//  home_set outside IDLE is ignored.
//  Latency: req seen in IDLE -> grant next cycle -> CALC -> RUN begins 2 cycles after grant.
//  Final counted step_e -> coord_run low 1 cycle later -> done SETTLE_CYCLES+1 cycles after that.
// TESTING  (SETTLE_CYCLES=8; bench drives step_fb as a 4-high/4-low square wave while coord_run is high)
//  1 Forward: cur_pos=0, req[0], pos 5 -> grant=0001, coord_dir=0, run drops 1 cycle after 5th edge, done=0001, aborted=0, cur_pos=5.
//  2 Reverse: cur_pos=5, req[1], pos 2 -> coord_dir=1, exactly 3 edges counted, done=0010, cur_pos=2.
//  3 Zero move: cur_pos=7, req[2], pos 7 -> coord_run never high, done=0100 3 cycles after grant.
//  4 Round robin: req=0101 held -> grants 0001 then 0100. Then req=1111 with ptr=3 -> grant 1000, then 0001.
//  5 Abort: req[3] pos 10, abort after 2nd edge -> coord_run low next cycle, done=1000, aborted=1, cur_pos=2.
//  6 Reset mid-RUN at cur_pos=4: all outputs 0, cur_pos=0, no done; after release a new req is granted normally.
//  7 home_set with req in IDLE same cycle -> cur_pos=0, grant 1 cycle later.

Source files
------------

// File: rtl/stepper_move_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_move_scheduler
//  Description : Round-robin scheduler for absolute-position moves of one
//                shared stepper axis. Tracks absolute position from step
//                feedback, drives the motor controller coordination lines
//                and reports completion after a settle period.
//  Revision    : 1.0 - initial release
// ============================================================================
module stepper_move_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int POS_WIDTH     = 16,
    parameter int SETTLE_CYCLES = 50_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*POS_WIDTH-1:0] req_pos,
    input  logic                         abort,
    input  logic                         home_set,
    input  logic                         step_fb,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           done,
    output logic                         aborted,
    output logic                         busy,
    output logic [POS_WIDTH-1:0]         cur_pos,
    output logic                         coord_enable,
    output logic                         coord_run,
    output logic                         coord_dir
);

    localparam int c_ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = $clog2(SETTLE_CYCLES + 1);

    // GRANT is the one-cycle grant pulse between arbitration and CALC
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_CALC   = 3'd2,
        S_RUN    = 3'd3,
        S_SETTLE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic                   r_step_q;
    logic                   w_step_e;
    logic [POS_WIDTH-1:0]   r_cur_pos;
    logic [POS_WIDTH-1:0]   r_target;
    logic [POS_WIDTH-1:0]   r_remaining;
    logic                   r_dir;
    logic                   r_aborted;
    logic [c_ID_W-1:0]      r_id;
    logic [c_ID_W-1:0]      r_ptr;
    logic [c_CNT_W-1:0]     r_settle_cnt;
    logic [NUM_REQ-1:0]     r_done;
    logic                   r_aborted_out;

    logic                   w_found;
    logic [c_ID_W-1:0]      w_pick;
    logic [c_ID_W-1:0]      w_idx;
    int                     w_scan;
    logic [POS_WIDTH-1:0]   w_req_target;
    logic                   w_dir_calc;
    logic [POS_WIDTH-1:0]   w_diff;
    logic [NUM_REQ-1:0]     w_id_onehot;
    logic                   w_accept;

    assign w_step_e = step_fb & ~r_step_q;

    // Round-robin search: first set request at or above the pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        w_scan  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = int'(r_ptr) + k;
            if (w_scan >= NUM_REQ) begin
                w_scan = w_scan - NUM_REQ;
            end
            w_idx = c_ID_W'(w_scan);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Target of the winning requester, plus direction/distance of the move
    always_comb begin
        w_req_target = req_pos[int'(w_pick)*POS_WIDTH +: POS_WIDTH];
        w_dir_calc   = (r_target < r_cur_pos);
        w_diff       = w_dir_calc ? (r_cur_pos - r_target) : (r_target - r_cur_pos);
        w_id_onehot  = '0;
        w_id_onehot[r_id] = 1'b1;
    end

    // home_set outranks a request in the same IDLE cycle
    assign w_accept = (r_state == S_IDLE) && !home_set && w_found;

    // State register; reset abandons any move without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and Moore outputs
    always_comb begin
        w_next       = r_state;
        grant        = '0;
        busy         = (r_state != S_IDLE);
        coord_enable = 1'b0;
        coord_run    = 1'b0;
        coord_dir    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_GRANT;
                end
            end
            S_GRANT: begin
                grant  = w_id_onehot;
                w_next = S_CALC;
            end
            S_CALC: begin
                if (abort || (w_diff == '0)) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                coord_enable = 1'b1;
                coord_run    = 1'b1;
                coord_dir    = r_dir;
                if (abort || (w_step_e && (r_remaining == POS_WIDTH'(1)))) begin
                    w_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                coord_enable = 1'b1;
                coord_dir    = r_dir;
                if (r_settle_cnt == c_CNT_W'(SETTLE_CYCLES - 1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Position tracking, move bookkeeping and the registered done report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_q      <= 1'b0;
            r_cur_pos     <= '0;
            r_target      <= '0;
            r_remaining   <= '0;
            r_dir         <= 1'b0;
            r_aborted     <= 1'b0;
            r_id          <= '0;
            r_ptr         <= '0;
            r_settle_cnt  <= '0;
            r_done        <= '0;
            r_aborted_out <= 1'b0;
        end else begin
            r_step_q <= step_fb;

            // Steps are counted in every state, using the last latched direction
            if ((r_state == S_IDLE) && home_set) begin
                r_cur_pos <= '0;
            end else if (w_step_e) begin
                r_cur_pos <= r_dir ? (r_cur_pos - POS_WIDTH'(1))
                                   : (r_cur_pos + POS_WIDTH'(1));
            end

            if (w_accept) begin
                r_id     <= w_pick;
                r_target <= w_req_target;
                r_ptr    <= (w_pick == c_ID_W'(NUM_REQ - 1)) ? '0
                                                             : (w_pick + c_ID_W'(1));
            end

            case (r_state)
                S_GRANT: begin
                    r_aborted <= 1'b0;
                end
                S_CALC: begin
                    r_dir       <= w_dir_calc;
                    r_remaining <= w_diff;
                    if (abort) begin
                        r_aborted <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_step_e) begin
                        r_remaining <= r_remaining - POS_WIDTH'(1);
                    end
                    if (abort) begin
                        r_aborted <= 1'b1;
                    end
                end
                default: begin
                end
            endcase

            r_settle_cnt  <= (r_state == S_SETTLE) ? (r_settle_cnt + c_CNT_W'(1)) : '0;
            r_done        <= (r_state == S_DONE) ? w_id_onehot : '0;
            r_aborted_out <= (r_state == S_DONE) && r_aborted;
        end
    end

    assign cur_pos = r_cur_pos;
    assign done    = r_done;
    assign aborted = r_aborted_out;

endmodule
`default_nettype wire

// File: tb/tb_stepper_move_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stepper_move_scheduler
//  Description : Directed self-checking bench for stepper_move_scheduler with
//                SETTLE_CYCLES=8 and a 4-high/4-low step feedback wave.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stepper_move_scheduler;

    localparam int c_NUM_REQ = 4;
    localparam int c_POS_W   = 16;
    localparam int c_SETTLE  = 8;

    logic                       clk;
    logic                       rst_n;
    logic [c_NUM_REQ-1:0]       req;
    logic [c_NUM_REQ*c_POS_W-1:0] req_pos;
    logic                       abort;
    logic                       home_set;
    logic                       step_fb;
    logic [c_NUM_REQ-1:0]       grant;
    logic [c_NUM_REQ-1:0]       done;
    logic                       aborted;
    logic                       busy;
    logic [c_POS_W-1:0]         cur_pos;
    logic                       coord_enable;
    logic                       coord_run;
    logic                       coord_dir;

    int n_vec   = 0;
    int n_err   = 0;
    int ph      = -1;
    int rise_cnt = 0;
    logic rose  = 1'b0;

    stepper_move_scheduler #(
        .NUM_REQ      (c_NUM_REQ),
        .POS_WIDTH    (c_POS_W),
        .SETTLE_CYCLES(c_SETTLE)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_pos     (req_pos),
        .abort       (abort),
        .home_set    (home_set),
        .step_fb     (step_fb),
        .grant       (grant),
        .done        (done),
        .aborted     (aborted),
        .busy        (busy),
        .cur_pos     (cur_pos),
        .coord_enable(coord_enable),
        .coord_run   (coord_run),
        .coord_dir   (coord_dir)
    );

    // 50 MHz clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; outputs sampled 1 ns after the edge, then the step wave advances
    task automatic tick();
        logic nxt;
        @(posedge clk);
        #1;
        rose = 1'b0;
        if (coord_run) begin
            ph  = (ph + 1) % 8;
            nxt = (ph < 4);
            rose = nxt & ~step_fb;
            step_fb = nxt;
            if (rose) rise_cnt++;
        end else begin
            ph = -1;
            step_fb = 1'b0;
        end
    endtask

    task automatic wait_grant(input string tag, input logic [3:0] exp);
        for (int c = 0; c < 60; c++) begin
            tick();
            if (grant != '0) break;
        end
        chk(tag, grant, exp);
    endtask

    task automatic wait_done(input string tag, input logic [3:0] exp);
        for (int c = 0; c < 60; c++) begin
            tick();
            if (done != '0) break;
        end
        chk(tag, done, exp);
    endtask

    // Full move: grant, run-start latency, direction, edge count, run drop,
    // settle latency, done/aborted and final position
    task automatic do_move(input int id, input logic [15:0] pos, input int abort_at,
                           input logic exp_dir, input int exp_edges,
                           input logic [15:0] exp_pos, input logic exp_ab);
        int t, run_t, last_rise_t, abort_t, drop_t, done_t, base;
        logic dir_seen;
        logic [3:0] oh;
        oh = 4'b0001 << id;
        req_pos[id*c_POS_W +: c_POS_W] = pos;
        req = oh;
        tick();
        chk("grant", grant, oh);
        req = '0;
        t = 0; run_t = -1; last_rise_t = -1; abort_t = -1; drop_t = -1; done_t = -1;
        dir_seen = 1'b0;
        base = rise_cnt;
        while (done_t < 0 && t < 400) begin
            tick();
            t++;
            if (coord_run && run_t < 0) begin
                run_t = t;
                dir_seen = coord_dir;
            end
            if (rose) last_rise_t = t;
            if (!coord_run && run_t >= 0 && drop_t < 0) begin
                drop_t = t;
                abort = 1'b0;
            end
            if (abort_at > 0 && abort_t < 0 && (rise_cnt - base) == abort_at
                && t == last_rise_t + 1) begin
                abort = 1'b1;
                abort_t = t;
            end
            if (done != '0) done_t = t;
        end
        if (exp_edges > 0) begin
            chk("run_start", run_t, 2);
            chk("dir", dir_seen, exp_dir);
            chk("edges", rise_cnt - base, exp_edges);
            chk("run_drop", drop_t - ((abort_at > 0) ? abort_t : last_rise_t), 1);
            chk("settle", done_t - drop_t, c_SETTLE + 1);
        end else begin
            chk("no_run", run_t, -1);
            chk("zero_lat", done_t, 3);
        end
        chk("done", done, oh);
        chk("aborted", aborted, exp_ab);
        chk("cur_pos", cur_pos, exp_pos);
        chk("idle_at_done", busy, 0);
        tick();
        chk("done_pulse", done, 0);
    endtask

    initial begin
        int hits;
        rst_n = 1'b0; req = '0; req_pos = '0; abort = 1'b0; home_set = 1'b0; step_fb = 1'b0;
        tick(); tick();
        chk("reset_outs", {grant, done, aborted, busy, cur_pos, coord_enable, coord_run, coord_dir}, 0);
        rst_n = 1'b1;
        tick();

        // Forward 0 -> 5
        do_move(0, 16'd5, 0, 1'b0, 5, 16'd5, 1'b0);
        // Reverse 5 -> 2
        do_move(1, 16'd2, 0, 1'b1, 3, 16'd2, 1'b0);
        // Forward 2 -> 7 on requester 3 (pointer wraps to 0)
        do_move(3, 16'd7, 0, 1'b0, 5, 16'd7, 1'b0);
        // Zero-length move at 7
        do_move(2, 16'd7, 0, 1'b0, 0, 16'd7, 1'b0);

        // Round robin with held requests, pointer at 3
        req_pos = {4{16'd7}};
        req = 4'b0101;
        wait_grant("rr_a", 4'b0001);
        wait_grant("rr_b", 4'b0100);
        req = 4'b1111;
        wait_grant("rr_c", 4'b1000);
        wait_grant("rr_d", 4'b0001);
        req = '0;
        wait_done("rr_done", 4'b0001);
        chk("rr_pos", cur_pos, 16'd7);
        tick();

        // home_set beats a same-cycle request
        req_pos[2*c_POS_W +: c_POS_W] = 16'd0;
        home_set = 1'b1;
        req = 4'b0100;
        tick();
        chk("home_pos", cur_pos, 0);
        chk("home_nogrant", grant, 0);
        home_set = 1'b0;
        tick();
        chk("home_grant", grant, 4'b0100);
        req = '0;
        wait_done("home_done", 4'b0100);
        tick();

        // Abort after the 2nd counted step
        do_move(3, 16'd10, 2, 1'b0, 2, 16'd2, 1'b1);

        // Reset in the middle of a run at position 4
        req_pos[0 +: c_POS_W] = 16'd9;
        req = 4'b0001;
        tick();
        chk("rst_grant", grant, 4'b0001);
        req = '0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (cur_pos == 16'd4) break;
        end
        chk("rst_prepos", cur_pos, 16'd4);
        chk("rst_prerun", coord_run, 1);
        rst_n = 1'b0;
        step_fb = 1'b0;
        #1;
        chk("rst_mid_outs", {grant, done, aborted, busy, cur_pos, coord_enable, coord_run, coord_dir}, 0);
        tick(); tick();
        rst_n = 1'b1;
        hits = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done != '0 || busy) hits++;
        end
        chk("rst_silent", hits, 0);
        do_move(1, 16'd3, 0, 1'b0, 3, 16'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
